// File: rtl/hall_call_encoder_pkg.sv
// hall_call_encoder_pkg: request codes, motion and encoder state types, index-to-code map.
// Rev 1.0
`default_nettype none

package hall_call_encoder_pkg;

  localparam logic [2:0] C_NONE = 3'b000;
  localparam logic [2:0] C_1U   = 3'b001;
  localparam logic [2:0] C_2U   = 3'b010;
  localparam logic [2:0] C_3U   = 3'b011;
  localparam logic [2:0] C_2D   = 3'b110;
  localparam logic [2:0] C_3D   = 3'b111;
  localparam logic [2:0] C_4D   = 3'b100;

  typedef enum logic [1:0] {
    STAY = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } motion_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } enc_state_t;

  // Button index order is 1U,2U,3U,2D,3D,4D.
  function automatic logic [2:0] code_of(input logic [2:0] idx);
    logic [2:0] code;
    code = C_NONE;
    case (idx)
      3'd0:    code = C_1U;
      3'd1:    code = C_2U;
      3'd2:    code = C_3U;
      3'd3:    code = C_2D;
      3'd4:    code = C_3D;
      3'd5:    code = C_4D;
      default: code = C_NONE;
    endcase
    return code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hall_call_encoder_if.sv
// hall_call_encoder_if: landing-button side and controller-din side signals of the encoder.
// Rev 1.0
`default_nettype none

interface hall_call_encoder_if;
  logic [5:0] btn;
  logic [2:0] din_out;
  logic       din_valid;
  logic [5:0] lamp;
  logic       busy;

  modport master (output btn, input din_out, input din_valid, input lamp, input busy);
  modport slave  (input btn, output din_out, output din_valid, output lamp, output busy);
endinterface

`default_nettype wire

// File: rtl/hall_call_encoder_rr_arbiter6.sv
// hall_call_encoder_rr_arbiter6: combinational round-robin search over six pending calls.
// Rev 1.0
`default_nettype none

module hall_call_encoder_rr_arbiter6 (
  input  logic [5:0] pending,
  input  logic [2:0] ptr,
  output logic [2:0] grant,
  output logic       found
);

  always_comb begin
    grant = 3'd0;
    found = 1'b0;
    for (int k = 0; k < 6; k++) begin
      logic [3:0] w_sum;
      logic [2:0] w_idx;
      w_sum = {1'b0, ptr} + 4'(k);
      w_idx = (w_sum >= 4'd6) ? 3'(w_sum - 4'd6) : w_sum[2:0];
      if (!found && pending[w_idx]) begin
        found = 1'b1;
        grant = w_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/hall_call_encoder.sv
// hall_call_encoder: latches hall calls, round-robin serialises them onto din with hold/gap timing.
// Optional macro HALL_CALL_SYNC_EN adds a 2-flop button synchronizer. Rev 1.0
`default_nettype none

module hall_call_encoder
  import hall_call_encoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 5,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hall_call_encoder_if.slave   bus
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] c_hold_load = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_gap_load  = CNT_W'(GAP_CYCLES - 1);

  logic [5:0]       w_btn_s;
  logic [5:0]       r_btn_d;
  logic [5:0]       r_pending;
  logic [2:0]       r_ptr;
  logic [2:0]       r_grant;
  logic [CNT_W-1:0] r_cnt;
  enc_state_t       r_state;
  logic [2:0]       r_din_out;
  logic             r_din_valid;

  logic [5:0]       w_rise;
  logic [2:0]       w_grant;
  logic             w_found;
  logic             w_take;
  logic [2:0]       w_ptr_next;
  logic [5:0]       w_clear;
  logic [5:0]       w_pending_next;

`ifdef HALL_CALL_SYNC_EN
  logic [5:0] r_sync1;
  logic [5:0] r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 6'd0;
      r_sync2 <= 6'd0;
    end else begin
      r_sync1 <= bus.btn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_btn_s = r_sync2;
`else
  assign w_btn_s = bus.btn;
`endif

  assign w_rise = w_btn_s & ~r_btn_d;

  hall_call_encoder_rr_arbiter6 u_arb (
    .pending (r_pending),
    .ptr     (r_ptr),
    .grant   (w_grant),
    .found   (w_found)
  );

  // A new grant is taken from IDLE, or straight out of the last GAP cycle.
  assign w_take = w_found &&
                  ((r_state == ST_IDLE) || ((r_state == ST_GAP) && (r_cnt == '0)));
  assign w_ptr_next = (w_grant == 3'd5) ? 3'd0 : w_grant + 3'd1;
  assign w_clear    = w_take ? (6'b000001 << w_grant) : 6'd0;
  // OR-ing the rise last lets a re-press of the granted call survive its own clear.
  assign w_pending_next = (r_pending & ~w_clear) | w_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_d     <= 6'd0;
      r_pending   <= 6'd0;
      r_ptr       <= 3'd0;
      r_grant     <= 3'd0;
      r_cnt       <= '0;
      r_state     <= ST_IDLE;
      r_din_out   <= C_NONE;
      r_din_valid <= 1'b0;
    end else begin
      r_btn_d   <= w_btn_s;
      r_pending <= w_pending_next;
      if (w_take) begin
        r_state     <= ST_HOLD;
        r_grant     <= w_grant;
        r_ptr       <= w_ptr_next;
        r_cnt       <= c_hold_load;
        r_din_out   <= code_of(w_grant);
        r_din_valid <= 1'b1;
      end else begin
        case (r_state)
          ST_HOLD: begin
            if (r_cnt == '0) begin
              r_state     <= ST_GAP;
              r_cnt       <= c_gap_load;
              r_din_out   <= C_NONE;
              r_din_valid <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          ST_GAP: begin
            if (r_cnt == '0) begin
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          default: begin
            r_state     <= ST_IDLE;
            r_din_out   <= C_NONE;
            r_din_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.din_out   = r_din_out;
  assign bus.din_valid = r_din_valid;
  assign bus.lamp      = r_pending |
                         ((r_state == ST_HOLD) ? (6'b000001 << r_grant) : 6'd0);
  assign bus.busy      = (r_pending != 6'd0) || (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_hall_call_encoder.sv
// tb_hall_call_encoder: directed and random stimulus against a slot-timing model of the encoder.
// Rev 1.0
`default_nettype none

module tb_hall_call_encoder;

  localparam int HOLD = 5;
  localparam int GAP  = 1;
`ifdef HALL_CALL_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst_n;
  hall_call_encoder_if bus ();

  hall_call_encoder #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;
  int n_starts;
  logic prev_valid;

  // Model: a transmission is a slot of HOLD+GAP cycles; m_t is the cycle within it.
  logic [5:0] m_pend;
  logic [5:0] m_bd;
  logic [5:0] m_s1;
  logic [5:0] m_s2;
  int         m_ptr;
  int         m_g;
  int         m_t;
  bit         m_active;
  int         code_tbl [6] = '{1, 2, 3, 6, 7, 4};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_pend = 6'd0; m_bd = 6'd0; m_s1 = 6'd0; m_s2 = 6'd0;
    m_ptr = 0; m_g = 0; m_t = 0; m_active = 0;
  endtask

  task automatic model_step(input logic [5:0] b);
    logic [5:0] bs;
    logic [5:0] rise;
    bit can_start;
`ifdef HALL_CALL_SYNC_EN
    bs = m_s2; m_s2 = m_s1; m_s1 = b;
`else
    bs = b;
`endif
    rise = bs & ~m_bd;
    m_bd = bs;
    can_start = !m_active || (m_t == HOLD + GAP - 1);
    if (m_active) begin
      m_t++;
      if (m_t == HOLD + GAP) m_active = 0;
    end
    if (can_start && m_pend != 6'd0) begin
      for (int o = 0; o < 6; o++) begin
        if (m_pend[(m_ptr + o) % 6]) begin
          m_g = (m_ptr + o) % 6;
          break;
        end
      end
      m_pend[m_g] = 1'b0;
      m_ptr = (m_g + 1) % 6;
      m_active = 1;
      m_t = 0;
    end
    m_pend = m_pend | rise;
  endtask

  task automatic compare_model();
    bit ev;
    logic [2:0] ed;
    logic [5:0] el;
    ev = m_active && (m_t < HOLD);
    ed = ev ? 3'(code_tbl[m_g]) : 3'd0;
    el = m_pend | (ev ? (6'b000001 << m_g) : 6'd0);
    check_eq("din_out", 32'(bus.din_out), 32'(ed));
    check_eq("din_valid", 32'(bus.din_valid), 32'(ev));
    check_eq("lamp", 32'(bus.lamp), 32'(el));
    check_eq("busy", 32'(bus.busy), 32'((m_pend != 6'd0) || m_active));
  endtask

  task automatic cycle(input logic [5:0] b);
    @(negedge clk);
    bus.btn = b;
    @(posedge clk);
    model_step(b);
    #1;
    compare_model();
    if (bus.din_valid && !prev_valid) n_starts++;
    prev_valid = bus.din_valid;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(6'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_din_out", 32'(bus.din_out), 32'd0);
    check_eq("rst_valid", 32'(bus.din_valid), 32'd0);
    check_eq("rst_lamp", 32'(bus.lamp), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    model_clear();
    prev_valid = 1'b0;
    @(negedge clk);
    bus.btn = 6'd0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [5:0] cur;
    n_cmp = 0; n_err = 0; n_starts = 0; prev_valid = 1'b0;
    model_clear();
    rst_n = 1'b0;
    bus.btn = 6'd0;
    repeat (3) @(negedge clk);
    check_eq("init_din_out", 32'(bus.din_out), 32'd0);
    check_eq("init_lamp", 32'(bus.lamp), 32'd0);
    check_eq("init_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;

    // Single 1U press: code after LAT cycles, then idle once slot ends.
    cycle(6'b000001);
    check_eq("t1_lamp_at_press", 32'(bus.lamp[0]), (LAT == 1) ? 32'd1 : 32'd0);
    run(LAT);
    check_eq("t1_code", 32'(bus.din_out), 32'd1);
    run(HOLD + GAP);
    check_eq("t1_busy_after", 32'(bus.busy), 32'd0);

    // Simultaneous 3U and 4D from ptr=0.
    do_reset();
    cycle(6'b100100);
    run(LAT);
    check_eq("t2_first", 32'(bus.din_out), 32'd3);
    run(HOLD + GAP);
    check_eq("t2_second", 32'(bus.din_out), 32'd4);
    run(HOLD + GAP);
    check_eq("t2_lamp_done", 32'(bus.lamp), 32'd0);

    // 2D held for 20 cycles yields a single transmission.
    n_starts = 0;
    for (int i = 0; i < 20; i++) cycle(6'b001000);
    run(10);
    check_eq("t3_starts", 32'(n_starts), 32'd1);

    // 2U re-pressed during its own HOLD is sent twice, lamp never drops.
    n_starts = 0;
    cycle(6'b000010);
    run(LAT + 1);
    cycle(6'b000010);
    for (int i = 0; i < HOLD + GAP + 1; i++) begin
      cycle(6'd0);
      check_eq("t4_lamp1", 32'(bus.lamp[1]), 32'd1);
    end
    run(HOLD + 6);
    check_eq("t4_starts", 32'(n_starts), 32'd2);

    // Reset mid-HOLD, then no spontaneous transmission.
    cycle(6'b010000);
    run(LAT + 2);
    check_eq("t5_in_hold", 32'(bus.din_valid), 32'd1);
    do_reset();
    n_starts = 0;
    run(15);
    check_eq("t5_no_tx", 32'(n_starts), 32'd0);

    // Random button levels with occasional asynchronous reset.
    cur = 6'd0;
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < 6; b++)
        if ($urandom_range(0, 9) == 0) cur[b] = ~cur[b];
      cycle(cur);
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        cur = 6'd0;
      end
    end
    run(HOLD * 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hall_call_encoder.md
Name: hall_call_encoder

Overview:
Transmit end of the hall-call interface into the elevator controller: converts six raw hall-call buttons into the serial 3-bit request code consumed on the controller's din input.
- Latches each press as a pending call and lights its lamp.
- Round-robin arbitrates among pending calls.
- Drives each granted code on din for a fixed hold window, then an idle gap, so back-to-back identical codes stay distinguishable.
- Sits between the landing-button I/O and E_FSM, replacing the bench-driven din stimulus.

Parameters:
HOLD_CYCLES, 5, cycles a granted code is held on din_out (>=1)
GAP_CYCLES, 1, cycles of idle code driven between successive codes (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
btn  input  6  hall buttons, level, index 0..5 = 1U,2U,3U,2D,3D,4D
din_out  output  3  request code to controller din: 1U=001, 2U=010, 3U=011, 2D=110, 3D=111, 4D=100, idle=000
din_valid  output  1  high while din_out carries a real code (HOLD state)
lamp  output  6  call-registered lamps, same indexing as btn
busy  output  1  high when any call is pending or a code is being held

Behaviour:
- Reset values: all outputs 0; pending=0; btn history=0; round-robin pointer=0; state=IDLE; counter=0.
- Reset can assert at any time and clears everything immediately.
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Edge detect: rise[i] = btn[i] & ~btn_d[i], where btn_d is a registered copy. A held button produces exactly one press.
- Pending: set on rise[i]; cleared for the granted index on the cycle the grant is taken. A rise on the index being granted in the same cycle wins, so the bit stays set and the call is resent later. A rise on an already-pending index has no effect.
- Arbiter: search pending from index ptr upward, mod 6; first set bit is the grant. After granting i, ptr = (i+1) mod 6.
- FSM (registered outputs):
  - IDLE: din_out=000, din_valid=0. If pending!=0, grant, load counter=HOLD_CYCLES-1, go to HOLD.
  - HOLD: din_out=code(grant), din_valid=1. Counter decrements each cycle. At 0, load counter=GAP_CYCLES-1 and go to GAP.
  - GAP: din_out=000, din_valid=0. At counter 0: if pending!=0, grant and go directly to HOLD; else go to IDLE.
- Latency: btn rising and sampled at posedge k sets pending at k; din_out shows the code from posedge k+1 when the FSM was in IDLE.
- Lamp: lamp[i] = pending[i] | (state==HOLD & grant==i). Lamp stays lit until the code's hold window ends.
- busy: busy = (pending!=0) | (state!=IDLE).
- Simultaneous presses: all latch in the same cycle and are served in round-robin order from ptr.
- Counter width is clog2 of max(HOLD_CYCLES, GAP_CYCLES), minimum 1 bit; no wrap beyond load value.

Optional Feature:
HALL_CALL_SYNC_EN
- Defined: btn passes through a 2-flop synchronizer (reset 0) before edge detection. Press-to-din latency grows by 2 cycles.
- Undefined: btn is used directly; btn must already be synchronous to clk.

Decomposition:
- Shared package elevator_pkg:
  - request-code constants C_1U..C_4D and C_NONE=000.
  - motion constants UP/DOWN/STAY.
  - encoder FSM state encodings.
  - function mapping index 0..5 to a 3-bit code.
- Natural sub-module: rr_arbiter6, combinational round-robin priority search. Inputs: pending, ptr. Outputs: grant index, found.

Test Plan:
- Reset then press btn[0] for 1 cycle at posedge k: din_out=001 with din_valid=1 for cycles k+1..k+5, then 000 for 1 cycle; lamp[0] high k..k+5; busy low after the gap.
- Press btn[2] and btn[5] in the same cycle with ptr=0: 011 held 5 cycles, 1 gap, then 100 held 5 cycles; lamps clear in that order.
- Hold btn[3] high for 20 cycles: exactly one 110 transmission.
- Re-press btn[1] during its own HOLD: 010 sent, gap, 010 sent again; a lamp[1] gap never occurs.
- Assert rst_n=0 mid-HOLD: din_out=000, lamp=0, busy=0 immediately; no transmission after release without a new press.
- With HALL_CALL_SYNC_EN defined, repeat test 1: first code appears at posedge k+3.
